// File: rtl/uart_duplex_if.sv
// CPU-side register bus of the duplex UART: TX FIFO push port,
// RX FIFO pop port with per-character status, and the sticky error flag.
interface uart_duplex_if;
    logic [31:0] wdata;
    logic        we;
    logic        full;
    logic        re;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        perr;
    logic        ferr;
    logic        overrun;
    logic        err_clr;

    // The bus owner (CPU / testbench) drives requests and reads status.
    modport master (
        output wdata, we, re, err_clr,
        input  full, rdata, rvalid, perr, ferr, overrun
    );

    // The UART serves the requests.
    modport slave (
        input  wdata, we, re, err_clr,
        output full, rdata, rvalid, perr, ferr, overrun
    );
endinterface

// File: rtl/uart_duplex.sv
// Full-duplex UART: TX FIFO feeding a serialiser, and a deserialiser
// feeding a first-word-fall-through RX FIFO that carries per-character
// parity/framing status. Frame format is fixed at elaboration.
module uart_duplex #(
    parameter int BAUD_DIV  = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_duplex_if.slave  bus,
    output logic          tx,
    input  logic          rx
);
    localparam int   TX_AW    = $clog2(TX_DEPTH);
    localparam int   RX_AW    = $clog2(RX_DEPTH);
    localparam int   STOP_LEN = STOP_BITS * BAUD_DIV;
    localparam int   CNT_W    = $clog2(STOP_LEN + 1);
    localparam int   HALF     = BAUD_DIV / 2;
    localparam int   RX_W     = DATA_BITS + 2;
    localparam logic ODD      = (PARITY == 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // Upper write-data bits carry no meaning for this frame width.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]       tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic                 tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[TX_AW] != tx_rd_ptr_reg[TX_AW]) &&
                      (tx_wr_ptr_reg[TX_AW-1:0] == tx_rd_ptr_reg[TX_AW-1:0]);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign tx_push  = bus.we && !tx_full;
    assign bus.full = tx_full;

    // TX storage write port (no reset so it maps onto RAM).
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg[TX_AW-1:0]] <= bus.wdata[DATA_BITS-1:0];
    end

    // TX FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    state_t               tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next;
    logic                 tx_line, tx_reg;

    // TX next-state: each state holds the line for one bit time; a new
    // frame is started straight from STOP when more data is queued.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg + 1'b1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_pop        = 1'b0;
        tx_line       = 1'b1;
        case (tx_state_reg)
            S_IDLE: begin
                tx_cnt_next = '0;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_shift_reg >> 1;
                    tx_par_next   = tx_par_reg ^ tx_shift_reg[0];
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    if (tx_bit_reg == LAST_BIT)
                        tx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx_line = tx_par_reg ^ ODD;
                if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                tx_line = 1'b1;
                if (tx_cnt_reg == STOP_END) begin
                    tx_cnt_next = '0;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_state_next = S_START;
                    end else begin
                        tx_state_next = S_IDLE;
                    end
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
    end

    // TX state register; the popped word is read from RAM into the shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_reg       <= tx_line;
            if (tx_pop) begin
                tx_shift_reg <= tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];
                tx_par_reg   <= 1'b0;
            end else begin
                tx_shift_reg <= tx_shift_next;
                tx_par_reg   <= tx_par_next;
            end
        end
    end

    assign tx = tx_reg;

    // ------------------------------------------------------------------
    // RX deserialiser
    // ------------------------------------------------------------------
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    state_t               rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_par_reg, rx_par_next;
    logic                 rx_perr_reg, rx_perr_next;
    logic                 rx_done;
    logic                 rx_full, rx_empty, rx_push, rx_pop;

    // RX next-state: first sample half a bit into START, then one sample
    // per bit time; back to IDLE right after the first stop sample.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 1'b1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_par_next   = rx_par_reg;
        rx_perr_next  = rx_perr_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            S_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg)
                    rx_state_next = S_START;
            end
            S_START: begin
                if (rx_cnt_reg == HALF_END) begin
                    rx_cnt_next  = '0;
                    rx_bit_next  = '0;
                    rx_par_next  = 1'b0;
                    rx_perr_next = 1'b0;
                    // A line already high again was only a glitch.
                    rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    rx_par_next   = rx_par_reg ^ rx_sync_reg;
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == LAST_BIT)
                        rx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_perr_next  = rx_sync_reg ^ rx_par_reg ^ ODD;
                    rx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_done       = 1'b1;
                    rx_state_next = S_IDLE;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_par_reg   <= 1'b0;
            rx_perr_reg  <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_par_reg   <= rx_par_next;
            rx_perr_reg  <= rx_perr_next;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (first-word-fall-through), entries are {ferr, perr, data}
    // ------------------------------------------------------------------
    logic [RX_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_W-1:0] rx_head;
    logic [7:0]      rx_head_data;
    logic            overrun_reg;

    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[RX_AW] != rx_rd_ptr_reg[RX_AW]) &&
                      (rx_wr_ptr_reg[RX_AW-1:0] == rx_rd_ptr_reg[RX_AW-1:0]);
    assign rx_push  = rx_done && !rx_full;
    assign rx_pop   = bus.re && !rx_empty;

    // RX storage write port; the stop sample itself is the framing status.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= {!rx_sync_reg, rx_perr_reg, rx_shift_reg};
    end

    // RX FIFO pointers and the sticky overrun flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_done && rx_full)
                overrun_reg <= 1'b1;
            else if (bus.err_clr)
                overrun_reg <= 1'b0;
        end
    end

    assign rx_head = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];

    // Zero-extend the head character to the 8-bit read port.
    always_comb begin
        rx_head_data = '0;
        rx_head_data[DATA_BITS-1:0] = rx_head[DATA_BITS-1:0];
    end

    // Head fields are masked while empty so the port reads zero.
    assign bus.rvalid  = !rx_empty;
    assign bus.rdata   = rx_empty ? 8'h00 : rx_head_data;
    assign bus.perr    = !rx_empty && rx_head[DATA_BITS];
    assign bus.ferr    = !rx_empty && rx_head[DATA_BITS+1];
    assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_uart_duplex.sv
// Directed bench for uart_duplex: three instances with different frame
// formats at BAUD_DIV=4, checked cycle by cycle against hand-derived frames.
module tb_uart_duplex;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic tx_a, tx_b, tx_c;
    logic rx_a, rx_b, rx_c;
    logic rx_drv_a, rx_drv_b, loop_a;

    uart_duplex_if ifa ();
    uart_duplex_if ifb ();
    uart_duplex_if ifc ();

    assign rx_a = loop_a ? tx_a : rx_drv_a;
    assign rx_b = rx_drv_b;
    assign rx_c = 1'b1;

    // A: 8N1, small FIFOs for full/overrun tests.
    uart_duplex #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .TX_DEPTH(4), .RX_DEPTH(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa), .tx(tx_a), .rx(rx_a));
    // B: 8E2.
    uart_duplex #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                  .TX_DEPTH(16), .RX_DEPTH(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb), .tx(tx_b), .rx(rx_b));
    // C: 8O2.
    uart_duplex #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                  .TX_DEPTH(16), .RX_DEPTH(16))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc), .tx(tx_c), .rx(rx_c));

    int n_vec = 0;
    int n_err = 0;

    // Expected line level k cycles after the start bit begins (BAUD_DIV=4,
    // 8 data bits, LSB first); pm: 0 none, 1 even, 2 odd.
    function automatic logic frame_level(input logic [7:0] d, input int pm, input int k);
        int b;
        if (k < 0) return 1'b1;
        b = k / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pm != 0 && b == 9) return (^d) ^ (pm == 2);
        return 1'b1;
    endfunction

    // Drive one serial frame on rx of A (sel=0) or B (sel=1), 4 cycles per bit.
    task automatic drive_frame(input int sel, input logic [7:0] d, input int has_par,
                               input logic pbit, input logic stopv);
        logic lv [0:10];
        int   n;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = d[i];
        if (has_par != 0) begin
            lv[9] = pbit; lv[10] = stopv; n = 11;
        end else begin
            lv[9] = stopv; lv[10] = 1'b1; n = 10;
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (sel == 0) rx_drv_a = lv[i]; else rx_drv_b = lv[i];
            end
        end
        @(negedge clk);
        if (sel == 0) rx_drv_a = 1'b1; else rx_drv_b = 1'b1;
        repeat (8) @(negedge clk);
        $display("rx frame driven on %s: data=0x%02h stop=%b", (sel == 0) ? "a" : "b", d, stopv);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
        n_vec++; if (tx_b !== 1'b1) begin n_err++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
        n_vec++; if (ifa.full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", ifa.full); end
        n_vec++; if (ifa.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", ifa.rvalid); end
        n_vec++; if (ifa.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%h exp=00", ifa.rdata); end
        n_vec++; if (ifa.perr !== 1'b0 || ifa.ferr !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", ifa.perr, ifa.ferr); end
        n_vec++; if (ifa.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", ifa.overrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_tx_frame;
        @(negedge clk);
        ifa.we = 1'b1; ifa.wdata = 32'hABCD_EF55;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifa.we = 1'b0;
                n_vec++; if (ifa.full !== 1'b0) begin n_err++; $display("FAIL tx_frame_full got=%b exp=0", ifa.full); end
            end
            n_vec++;
            if (tx_a !== frame_level(8'h55, 0, k - 3)) begin
                n_err++; $display("FAIL tx_frame_55 cycle=%0d got=%b exp=%b", k, tx_a, frame_level(8'h55, 0, k - 3));
            end
        end
        $display("tx frame 0x55 8N1 checked");
    endtask

    task automatic test_parity;
        @(negedge clk);
        ifb.we = 1'b1; ifb.wdata = 32'h07;
        ifc.we = 1'b1; ifc.wdata = 32'h07;
        for (int k = 1; k <= 54; k++) begin
            @(negedge clk);
            ifb.we = 1'b0; ifc.we = 1'b0;
            n_vec++;
            if (tx_b !== frame_level(8'h07, 1, k - 3)) begin
                n_err++; $display("FAIL tx_even cycle=%0d got=%b exp=%b", k, tx_b, frame_level(8'h07, 1, k - 3));
            end
            n_vec++;
            if (tx_c !== frame_level(8'h07, 2, k - 3)) begin
                n_err++; $display("FAIL tx_odd cycle=%0d got=%b exp=%b", k, tx_c, frame_level(8'h07, 2, k - 3));
            end
        end
        $display("tx frame 0x07 8E2 and 8O2 checked");
    endtask

    task automatic test_back_to_back;
        logic exp_tx;
        int   f;
        @(negedge clk);
        ifa.we = 1'b1; ifa.wdata = 32'h0;
        for (int k = 1; k <= 210; k++) begin
            @(negedge clk);
            if (k <= 7) begin
                n_vec++;
                if (ifa.full !== (k >= 5)) begin n_err++; $display("FAIL b2b_full cycle=%0d got=%b exp=%b", k, ifa.full, (k >= 5)); end
            end
            if (k == 41) begin
                n_vec++; if (ifa.full !== 1'b1) begin n_err++; $display("FAIL b2b_full_hold got=%b exp=1", ifa.full); end
            end
            if (k == 42) begin
                n_vec++; if (ifa.full !== 1'b0) begin n_err++; $display("FAIL b2b_full_release got=%b exp=0", ifa.full); end
            end
            if (k < 3) begin
                exp_tx = 1'b1;
            end else begin
                f = (k - 3) / 40;
                exp_tx = (f > 4) ? 1'b1 : frame_level(8'(f), 0, k - 3 - 40 * f);
            end
            n_vec++;
            if (tx_a !== exp_tx) begin n_err++; $display("FAIL b2b_tx cycle=%0d got=%b exp=%b", k, tx_a, exp_tx); end
            ifa.we = (k <= 6);
            ifa.wdata = 32'(k);
        end
        ifa.we = 1'b0;
        $display("tx back-to-back 0x00..0x04 with 0x05,0x06 dropped checked");
    endtask

    task automatic test_loopback;
        loop_a = 1'b1;
        @(negedge clk); ifa.we = 1'b1; ifa.wdata = 32'hA3;
        @(negedge clk); ifa.wdata = 32'h3C;
        @(negedge clk); ifa.we = 1'b0;
        repeat (100) @(negedge clk);
        n_vec++; if (ifa.rvalid !== 1'b1) begin n_err++; $display("FAIL loop_rvalid1 got=%b exp=1", ifa.rvalid); end
        n_vec++; if (ifa.rdata !== 8'hA3) begin n_err++; $display("FAIL loop_rdata1 got=%h exp=a3", ifa.rdata); end
        n_vec++; if (ifa.perr !== 1'b0 || ifa.ferr !== 1'b0) begin n_err++; $display("FAIL loop_err got=%b%b exp=00", ifa.perr, ifa.ferr); end
        ifa.re = 1'b1; @(negedge clk); ifa.re = 1'b0;
        n_vec++; if (ifa.rvalid !== 1'b1) begin n_err++; $display("FAIL loop_rvalid2 got=%b exp=1", ifa.rvalid); end
        n_vec++; if (ifa.rdata !== 8'h3C) begin n_err++; $display("FAIL loop_rdata2 got=%h exp=3c", ifa.rdata); end
        ifa.re = 1'b1; @(negedge clk); ifa.re = 1'b0;
        n_vec++; if (ifa.rvalid !== 1'b0) begin n_err++; $display("FAIL loop_empty got=%b exp=0", ifa.rvalid); end
        n_vec++; if (ifa.rdata !== 8'h00) begin n_err++; $display("FAIL loop_rdata_empty got=%h exp=00", ifa.rdata); end
        loop_a = 1'b0;
        repeat (4) @(negedge clk);
        $display("loopback 0xa3, 0x3c checked");
    endtask

    task automatic test_rx_errors;
        drive_frame(1, 8'h07, 1, 1'b1, 1'b1);
        n_vec++; if (ifb.rvalid !== 1'b1) begin n_err++; $display("FAIL rx_good_rvalid got=%b exp=1", ifb.rvalid); end
        n_vec++; if (ifb.perr !== 1'b0) begin n_err++; $display("FAIL rx_good_perr got=%b exp=0", ifb.perr); end
        n_vec++; if (ifb.rdata !== 8'h07) begin n_err++; $display("FAIL rx_good_rdata got=%h exp=07", ifb.rdata); end
        ifb.re = 1'b1; @(negedge clk); ifb.re = 1'b0;

        drive_frame(1, 8'h07, 1, 1'b0, 1'b1);
        n_vec++; if (ifb.rvalid !== 1'b1) begin n_err++; $display("FAIL rx_perr_rvalid got=%b exp=1", ifb.rvalid); end
        n_vec++; if (ifb.perr !== 1'b1) begin n_err++; $display("FAIL rx_perr got=%b exp=1", ifb.perr); end
        n_vec++; if (ifb.ferr !== 1'b0) begin n_err++; $display("FAIL rx_perr_ferr got=%b exp=0", ifb.ferr); end
        n_vec++; if (ifb.rdata !== 8'h07) begin n_err++; $display("FAIL rx_perr_rdata got=%h exp=07", ifb.rdata); end
        ifb.re = 1'b1; @(negedge clk); ifb.re = 1'b0;
        n_vec++; if (ifb.rvalid !== 1'b0) begin n_err++; $display("FAIL rx_perr_pop got=%b exp=0", ifb.rvalid); end

        drive_frame(0, 8'h5A, 0, 1'b0, 1'b0);
        n_vec++; if (ifa.rvalid !== 1'b1) begin n_err++; $display("FAIL rx_ferr_rvalid got=%b exp=1", ifa.rvalid); end
        n_vec++; if (ifa.ferr !== 1'b1) begin n_err++; $display("FAIL rx_ferr got=%b exp=1", ifa.ferr); end
        n_vec++; if (ifa.perr !== 1'b0) begin n_err++; $display("FAIL rx_ferr_perr got=%b exp=0", ifa.perr); end
        n_vec++; if (ifa.rdata !== 8'h5A) begin n_err++; $display("FAIL rx_ferr_rdata got=%h exp=5a", ifa.rdata); end
        ifa.re = 1'b1; @(negedge clk); ifa.re = 1'b0;

        @(negedge clk); rx_drv_a = 1'b0;
        @(negedge clk); rx_drv_a = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (ifa.rvalid !== 1'b0) begin n_err++; $display("FAIL rx_glitch got=%b exp=0", ifa.rvalid); end
        $display("rx parity, framing and glitch checked");
    endtask

    task automatic test_overrun;
        drive_frame(0, 8'h11, 0, 1'b0, 1'b1);
        drive_frame(0, 8'h22, 0, 1'b0, 1'b1);
        n_vec++; if (ifa.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got=%b exp=0", ifa.overrun); end
        drive_frame(0, 8'h33, 0, 1'b0, 1'b1);
        n_vec++; if (ifa.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", ifa.overrun); end
        n_vec++; if (ifa.rdata !== 8'h11) begin n_err++; $display("FAIL ovr_head1 got=%h exp=11", ifa.rdata); end
        ifa.err_clr = 1'b1; @(negedge clk); ifa.err_clr = 1'b0;
        n_vec++; if (ifa.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr got=%b exp=0", ifa.overrun); end
        ifa.re = 1'b1; @(negedge clk); ifa.re = 1'b0;
        n_vec++; if (ifa.rdata !== 8'h22) begin n_err++; $display("FAIL ovr_head2 got=%h exp=22", ifa.rdata); end
        ifa.re = 1'b1; @(negedge clk); ifa.re = 1'b0;
        n_vec++; if (ifa.rvalid !== 1'b0) begin n_err++; $display("FAIL ovr_drop got=%b exp=0", ifa.rvalid); end
        $display("overrun with third character dropped checked");
    endtask

    task automatic test_reset_mid_frame;
        drive_frame(0, 8'h44, 0, 1'b0, 1'b1);
        n_vec++; if (ifa.rvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_rvalid got=%b exp=1", ifa.rvalid); end
        @(negedge clk); ifa.we = 1'b1; ifa.wdata = 32'h00;
        @(negedge clk); ifa.we = 1'b0;
        repeat (12) @(negedge clk);
        n_vec++; if (tx_a !== 1'b0) begin n_err++; $display("FAIL rst_pre_tx got=%b exp=0", tx_a); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL rst_async_tx got=%b exp=1", tx_a); end
        n_vec++; if (ifa.rvalid !== 1'b0) begin n_err++; $display("FAIL rst_async_rvalid got=%b exp=0", ifa.rvalid); end
        n_vec++; if (ifa.rdata !== 8'h00) begin n_err++; $display("FAIL rst_async_rdata got=%h exp=00", ifa.rdata); end
        @(negedge clk); rst_n = 1'b1;
        repeat (50) @(negedge clk);
        n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL rst_after_tx got=%b exp=1", tx_a); end
        $display("asynchronous reset mid-frame checked");
    endtask

    initial begin
        ifa.we = 1'b0; ifa.wdata = '0; ifa.re = 1'b0; ifa.err_clr = 1'b0;
        ifb.we = 1'b0; ifb.wdata = '0; ifb.re = 1'b0; ifb.err_clr = 1'b0;
        ifc.we = 1'b0; ifc.wdata = '0; ifc.re = 1'b0; ifc.err_clr = 1'b0;
        rx_drv_a = 1'b1; rx_drv_b = 1'b1; loop_a = 1'b0;
        test_reset();
        test_tx_frame();
        test_parity();
        test_back_to_back();
        test_loopback();
        test_rx_errors();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_duplex.md
# uart_duplex

Parametrised full-duplex UART for the SoC peripheral bus, replacing the TX-only UART. It has a TX FIFO that accepts CPU writes and serialises frames on `tx`, and an RX path that deserialises `rx` into an RX FIFO. Frame format is set at elaboration time: data bits, parity and stop bits. Per-character error flags travel with each received character, and a sticky overrun flag records dropped characters.

## Interface
- `BAUD_DIV`, 16: clk cycles per bit; legal ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal 5..8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `TX_DEPTH`, 16: TX FIFO entries; power of 2, ≥ 2.
- `RX_DEPTH`, 16: RX FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wdata`  in  32  TX data; bits [DATA_BITS-1:0] used, rest ignored.
- `we`  in  1  push `wdata` into TX FIFO.
- `full`  out  1  TX FIFO full.
- `tx`  out  1  serial out, idle high.
- `rx`  in  1  serial in, asynchronous.
- `re`  in  1  pop RX FIFO head.
- `rdata`  out  8  RX FIFO head data, zero-extended above DATA_BITS.
- `rvalid`  out  1  RX FIFO non-empty.
- `perr`  out  1  head character had a parity error.
- `ferr`  out  1  head character had a stop-bit (framing) error.
- `overrun`  out  1  sticky: a character was dropped because the RX FIFO was full.
- `err_clr`  in  1  clears `overrun`.

## Operation
- **Reset values:** `tx`=1, `full`=0, `rvalid`=0, `rdata`=0, `perr`=0, `ferr`=0, `overrun`=0. Both FIFOs are emptied, both FSMs go to IDLE, baud counters clear.
- **TX FIFO write rules:**
  - `we` && !`full`: write accepted.
  - `we` while `full`: write dropped. This holds even if a pop happens in the same cycle.
- **TX FSM:** IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE, or → START directly if the FIFO is non-empty.
  - Data is sent LSB first.
  - Even parity: parity bit = XOR of the data bits. Odd parity: its inverse.
  - STOP lasts `STOP_BITS`×`BAUD_DIV` cycles.
- **RX input synchronisation:** `rx` passes through a 2-flop synchroniser, reset value 1.
- **RX FSM:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - Leaves IDLE on a synchronised high-to-low transition.
  - Samples at `BAUD_DIV/2` cycles into START. If the line is high there, the start is false and the FSM returns to IDLE with nothing written.
  - Each later bit is sampled exactly `BAUD_DIV` cycles after the previous sample.
  - Only the first stop bit is checked. If it samples 0, `ferr` is set for that character.
  - After the stop sample the FSM returns to IDLE immediately, so back-to-back frames are received.
- **RX FIFO entries** hold {ferr, perr, data}. The FIFO is first-word-fall-through: `rdata`/`perr`/`ferr` show the head whenever `rvalid`=1.
  - `re` && `rvalid`: pop.
  - `re` while empty: ignored.
- **RX FIFO full at stop sample:** the character is discarded and `overrun` is set.
  - `overrun` holds until `err_clr`.
  - If `err_clr` and a new overrun occur in the same cycle, set wins.
- **Simultaneous operations:** push and pop in the same cycle are legal on each FIFO when it is neither empty (for the pop) nor blocked (for the push). Occupancy is then unchanged.

## Timing
- **TX latency:** `we` into an empty FIFO with TX idle at edge N → pop at edge N+1 → `tx` goes low after edge N+2.
- **TX frame length:** (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `BAUD_DIV` cycles. With a non-empty FIFO, consecutive frames have no idle gap.
- **`full` timing:** asserts the cycle after the write that fills the FIFO. Deasserts the cycle after the pop that frees a slot.
- **RX delivery:** `rvalid` rises 1 cycle after the clock edge where the stop bit is sampled.
- **RX sampling accuracy:** sample points sit within ±1 cycle of bit centre, plus the 2-cycle synchroniser delay.
- **Reset mid-frame:** `tx` returns high asynchronously. A partial RX character is discarded.

## Test plan
- **TX frame shape:** `BAUD_DIV`=4, 8N1, write 0x55 → `tx` low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high. Frame is 40 cycles.
- **Even parity, 2 stop bits:** `PARITY`=1, `STOP_BITS`=2, write 0x07 → parity bit 1, two stop bits, 48-cycle frame. With `PARITY`=2 the parity bit is 0.
- **TX back-to-back and full:** `TX_DEPTH`=4, write 0x00..0x06 on consecutive cycles → `full` asserts after the FIFO fills. Transmitted bytes are 0x00, 0x01, 0x02, 0x03, 0x04, with writes 0x05 and 0x06 dropped. Frames are contiguous with no idle gap.
- **RX loopback:** `tx` wired to `rx`, send 0xA3, 0x3C → `rvalid`=1, `rdata`=0xA3, `perr`=`ferr`=0. After `re`, head is 0x3C. After a second `re`, `rvalid`=0.
- **RX errors:** drive a frame with a flipped parity bit → head `perr`=1. Drive stop=0 → `ferr`=1. Drive a 1-cycle low glitch → no entry written.
- **Overrun and reset:** `RX_DEPTH`=2, receive 3 characters with no `re` → first two are kept, third is dropped, `overrun`=1. Pulse `err_clr` → `overrun`=0. Assert `rst_n`=0 mid-TX-frame → `tx`=1 and `rvalid`=0 immediately.
